// File: rtl/vga_box_renderer.sv
// Bouncing-box pixel colour stage: 2-cycle RGB pipeline plus a per-frame motion FSM.
// Optional red screen border enabled by defining VGA_BOX_BORDER_EN.
module vga_box_renderer #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2,
    parameter int X0       = 100,
    parameter int Y0       = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_active,
    input  logic       frame_start,
    input  logic       move_en,
    output logic [7:0] VGAR,
    output logic [7:0] VGAG,
    output logic [7:0] VGAB,
    output logic       pix_valid,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {WAIT, MOVE_X, MOVE_Y, COMMIT} state_t;

    localparam logic [10:0] MAXX   = 11'(H_RES - BOX_SIZE);
    localparam logic [10:0] MAXY   = 11'(V_RES - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);

    state_t      state_q, state_d;
    logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic [10:0] nx_q, nx_d, ny_q, ny_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        in_box_q, in_box_d, active_q, active_d;
    logic [23:0] rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] px, py;
`ifdef VGA_BOX_BORDER_EN
    logic        border_q, border_d;
`endif

    assign px = {1'b0, pix_x};
    assign py = {1'b0, pix_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT;
            box_x_q     <= 11'(X0);
            box_y_q     <= 11'(Y0);
            nx_q        <= 11'(X0);
            ny_q        <= 11'(Y0);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            frame_cnt_q <= 8'd0;
            in_box_q    <= 1'b0;
            active_q    <= 1'b0;
            rgb_q       <= 24'h000000;
            pix_valid_q <= 1'b0;
`ifdef VGA_BOX_BORDER_EN
            border_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            frame_cnt_q <= frame_cnt_d;
            in_box_q    <= in_box_d;
            active_q    <= active_d;
            rgb_q       <= rgb_d;
            pix_valid_q <= pix_valid_d;
`ifdef VGA_BOX_BORDER_EN
            border_q    <= border_d;
`endif
        end
    end

    // Motion: shadow nx/ny are built over two cycles and only land on the visible position in COMMIT.
    always_comb begin
        state_d     = state_q;
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            WAIT: begin
                if (frame_start && move_en) state_d = MOVE_X;
            end
            MOVE_X: begin
                state_d = MOVE_Y;
                if (dir_x_q) begin
                    if (box_x_q + STEP_W > MAXX) begin
                        nx_d    = MAXX;
                        dir_x_d = 1'b0;
                    end else begin
                        nx_d = box_x_q + STEP_W;
                    end
                end else if (box_x_q < STEP_W) begin
                    nx_d    = 11'd0;
                    dir_x_d = 1'b1;
                end else begin
                    nx_d = box_x_q - STEP_W;
                end
            end
            MOVE_Y: begin
                state_d = COMMIT;
                if (dir_y_q) begin
                    if (box_y_q + STEP_W > MAXY) begin
                        ny_d    = MAXY;
                        dir_y_d = 1'b0;
                    end else begin
                        ny_d = box_y_q + STEP_W;
                    end
                end else if (box_y_q < STEP_W) begin
                    ny_d    = 11'd0;
                    dir_y_d = 1'b1;
                end else begin
                    ny_d = box_y_q - STEP_W;
                end
            end
            COMMIT: begin
                state_d     = WAIT;
                box_x_d     = nx_q;
                box_y_d     = ny_q;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            default: state_d = WAIT;
        endcase
    end

    // Pixel pipeline: stage 1 classifies the coordinate, stage 2 picks the colour.
    always_comb begin
        in_box_d    = (px >= box_x_q) && (px < box_x_q + SIZE_W) &&
                      (py >= box_y_q) && (py < box_y_q + SIZE_W);
        active_d    = pix_active;
        pix_valid_d = active_q;
        rgb_d       = 24'h000000;
`ifdef VGA_BOX_BORDER_EN
        border_d    = (px == 11'd0) || (px == 11'(H_RES - 1)) ||
                      (py == 11'd0) || (py == 11'(V_RES - 1));
`endif
        if (active_q) begin
            if (in_box_q) rgb_d = 24'hFFFFFF;
`ifdef VGA_BOX_BORDER_EN
            else if (border_q) rgb_d = 24'hFF0000;
`endif
            else rgb_d = 24'h000080;
        end
    end

    assign VGAR      = rgb_q[23:16];
    assign VGAG      = rgb_q[15:8];
    assign VGAB      = rgb_q[7:0];
    assign pix_valid = pix_valid_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed self-checking bench for vga_box_renderer; a second instance with a short
// screen height exercises the top-edge bounce.
module tb_vga_box_renderer;

    logic       clk;
    logic       rst;
    logic [9:0] pix_x, pix_y;
    logic       pix_active, frame_start, move_en, move_en2;
    logic [7:0] VGAR, VGAG, VGAB, frame_cnt;
    logic       pix_valid;
    logic [7:0] r2, g2, b2, frame_cnt2;
    logic       pix_valid2;
    int         checks = 0;
    int         fails = 0;

    vga_box_renderer dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .frame_start(frame_start), .move_en(move_en), .VGAR(VGAR), .VGAG(VGAG), .VGAB(VGAB),
        .pix_valid(pix_valid), .frame_cnt(frame_cnt)
    );

    vga_box_renderer #(.V_RES(41), .Y0(7)) dut2 (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .frame_start(frame_start), .move_en(move_en2), .VGAR(r2), .VGAG(g2), .VGAB(b2),
        .pix_valid(pix_valid2), .frame_cnt(frame_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic render(input logic [9:0] x, input logic [9:0] y, input logic act,
                          output logic [23:0] rgb, output logic vld, output logic [23:0] rgb_b);
        @(negedge clk);
        pix_x = x; pix_y = y; pix_active = act;
        repeat (3) @(posedge clk);
        #1;
        rgb = {VGAR, VGAG, VGAB};
        vld = pix_valid;
        rgb_b = {r2, g2, b2};
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_x = 10'd100; pix_y = 10'd50; pix_active = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({VGAR, VGAG, VGAB} !== 24'h000000) begin
            fails++; $display("[TB] FAIL reset_rgb got %h want 000000", {VGAR, VGAG, VGAB});
        end
        checks++;
        if (pix_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_valid got %b want 0", pix_valid);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_render();
        logic [9:0]  tx [0:7] = '{10'd100, 10'd99, 10'd131, 10'd132, 10'd100, 10'd131, 10'd100, 10'd300};
        logic [9:0]  ty [0:7] = '{10'd50, 10'd50, 10'd81, 10'd50, 10'd49, 10'd82, 10'd50, 10'd300};
        logic        ta [0:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [23:0] te [0:7] = '{24'hFFFFFF, 24'h000080, 24'hFFFFFF, 24'h000080,
                                  24'h000080, 24'h000080, 24'h000000, 24'h000000};
        logic [23:0] rgb, rgb_b;
        logic        vld;
        for (int i = 0; i < 8; i++) begin
            render(tx[i], ty[i], ta[i], rgb, vld, rgb_b);
            checks++;
            if (rgb !== te[i]) begin
                fails++; $display("[TB] FAIL render_rgb(%0d,%0d,%b) got %h want %h", tx[i], ty[i], ta[i], rgb, te[i]);
            end
            checks++;
            if (vld !== ta[i]) begin
                fails++; $display("[TB] FAIL render_valid(%0d,%0d) got %b want %b", tx[i], ty[i], vld, ta[i]);
            end
        end
    endtask

    task automatic test_border();
        logic [23:0] rgb, rgb_b, want;
        logic        vld;
`ifdef VGA_BOX_BORDER_EN
        want = 24'hFF0000;
`else
        want = 24'h000080;
`endif
        render(10'd0, 10'd300, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== want) begin
            fails++; $display("[TB] FAIL border_left got %h want %h", rgb, want);
        end
        render(10'd639, 10'd479, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== want) begin
            fails++; $display("[TB] FAIL border_corner got %h want %h", rgb, want);
        end
    endtask

    task automatic test_move();
        logic [23:0] rgb, rgb_b;
        logic        vld;
        @(negedge clk);
        move_en = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (frame_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL move_early_cnt got %0d want 0", frame_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_cnt !== 8'd1) begin
            fails++; $display("[TB] FAIL move_commit_cnt got %0d want 1", frame_cnt);
        end
        render(10'd100, 10'd50, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'h000080) begin
            fails++; $display("[TB] FAIL move_old_corner got %h want 000080", rgb);
        end
        render(10'd102, 10'd52, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL move_new_corner got %h want FFFFFF", rgb);
        end
        render(10'd133, 10'd83, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL move_new_far got %h want FFFFFF", rgb);
        end
    endtask

    task automatic test_frame_during_move_y();
        logic [23:0] rgb, rgb_b;
        logic        vld;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (frame_cnt !== 8'd2) begin
            fails++; $display("[TB] FAIL retrigger_cnt got %0d want 2", frame_cnt);
        end
        render(10'd104, 10'd54, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL retrigger_box got %h want FFFFFF", rgb);
        end
        render(10'd103, 10'd54, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'h000080) begin
            fails++; $display("[TB] FAIL retrigger_left got %h want 000080", rgb);
        end
    endtask

    task automatic test_move_en_hold();
        logic [23:0] rgb, rgb_b;
        logic        vld;
        move_en = 1'b0;
        repeat (5) frame_pulse();
        checks++;
        if (frame_cnt !== 8'd2) begin
            fails++; $display("[TB] FAIL hold_cnt got %0d want 2", frame_cnt);
        end
        render(10'd104, 10'd54, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL hold_box got %h want FFFFFF", rgb);
        end
        render(10'd103, 10'd54, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'h000080) begin
            fails++; $display("[TB] FAIL hold_left got %h want 000080", rgb);
        end
        move_en = 1'b1;
    endtask

    task automatic test_reset_mid_fsm();
        logic [23:0] rgb, rgb_b;
        logic        vld;
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #2;
        frame_start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (frame_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL midrst_cnt got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (frame_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL midrst_cnt_after got %0d want 0", frame_cnt);
        end
        render(10'd100, 10'd50, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL midrst_home got %h want FFFFFF", rgb);
        end
        render(10'd132, 10'd50, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'h000080) begin
            fails++; $display("[TB] FAIL midrst_right got %h want 000080", rgb);
        end
        frame_pulse();
        checks++;
        if (frame_cnt !== 8'd1) begin
            fails++; $display("[TB] FAIL midrst_resume_cnt got %0d want 1", frame_cnt);
        end
        render(10'd102, 10'd52, 1'b1, rgb, vld, rgb_b);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            fails++; $display("[TB] FAIL midrst_resume_box got %h want FFFFFF", rgb);
        end
    endtask

    task automatic test_right_bounce();
        logic [9:0]  ex [0:3] = '{10'd606, 10'd608, 10'd608, 10'd606};
        logic [9:0]  ey [0:3] = '{10'd342, 10'd340, 10'd338, 10'd336};
        logic [7:0]  ec [0:3] = '{8'd253, 8'd254, 8'd255, 8'd0};
        logic [23:0] rgb, rgb_b;
        logic        vld;
        repeat (252) frame_pulse();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) frame_pulse();
            checks++;
            if (frame_cnt !== ec[i]) begin
                fails++; $display("[TB] FAIL right_cnt[%0d] got %0d want %0d", i, frame_cnt, ec[i]);
            end
            render(ex[i], ey[i], 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb !== 24'hFFFFFF) begin
                fails++; $display("[TB] FAIL right_corner[%0d] got %h want FFFFFF", i, rgb);
            end
            render(ex[i] - 10'd1, ey[i], 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb !== 24'h000080) begin
                fails++; $display("[TB] FAIL right_left[%0d] got %h want 000080", i, rgb);
            end
            render(ex[i], ey[i] - 10'd1, 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb !== 24'h000080) begin
                fails++; $display("[TB] FAIL right_above[%0d] got %h want 000080", i, rgb);
            end
        end
    endtask

    task automatic test_top_bounce();
        logic [9:0]  ex [0:2] = '{10'd112, 10'd114, 10'd116};
        logic [9:0]  ey [0:2] = '{10'd1, 10'd0, 10'd2};
        logic [7:0]  ec [0:2] = '{8'd6, 8'd7, 8'd8};
        logic [23:0] rgb, rgb_b;
        logic        vld;
        move_en = 1'b0;
        move_en2 = 1'b1;
        repeat (5) frame_pulse();
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            checks++;
            if (frame_cnt2 !== ec[i]) begin
                fails++; $display("[TB] FAIL top_cnt[%0d] got %0d want %0d", i, frame_cnt2, ec[i]);
            end
            render(ex[i], ey[i] + 10'd31, 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb_b !== 24'hFFFFFF) begin
                fails++; $display("[TB] FAIL top_bottom_row[%0d] got %h want FFFFFF", i, rgb_b);
            end
            render(ex[i], ey[i] + 10'd32, 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb_b !== 24'h000080) begin
                fails++; $display("[TB] FAIL top_below[%0d] got %h want 000080", i, rgb_b);
            end
            render(ex[i] - 10'd1, ey[i] + 10'd31, 1'b1, rgb, vld, rgb_b);
            checks++;
            if (rgb_b !== 24'h000080) begin
                fails++; $display("[TB] FAIL top_left[%0d] got %h want 000080", i, rgb_b);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pix_x = 10'd0; pix_y = 10'd0; pix_active = 1'b0;
        frame_start = 1'b0; move_en = 1'b0; move_en2 = 1'b0;
        test_reset();
        test_render();
        test_border();
        test_move();
        test_frame_during_move_y();
        test_move_en_hold();
        test_reset_mid_fsm();
        test_right_bounce();
        test_top_bounce();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
